bin8_to_bcd_seq: RTL

BIN8_TO_BCD_SEQ -- requirements
Module: bin8_to_bcd_seq

---
 rtl/bin8_to_bcd_seq.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/bin8_to_bcd_seq.sv
// bin8_to_bcd_seq
//   Sequential 8-bit binary to 3-digit BCD converter (double-dabble, one bit
//   per clock). A conversion accepted at one edge produces a one-cycle done
//   pulse 8 cycles later, so a held start gives one result every 9 cycles.
//
// Parameters
//   SIGNED   : 1 = value is two's complement (magnitude + neg reported),
//              0 = value is unsigned (neg always 0).
// Ports
//   clk      : in  - clock, all state changes on the rising edge
//   rst      : in  - synchronous active-high reset
//   start    : in  - request a conversion of value (ignored while busy)
//   value    : in  - 8-bit number to convert
//   busy     : out - conversion in progress
//   done     : out - one-cycle pulse when hundreds/tens/ones/neg update
//   neg      : out - sign of the last converted value
//   hundreds : out - BCD hundreds digit of the magnitude (0..2)
//   tens     : out - BCD tens digit of the magnitude
//   ones     : out - BCD ones digit of the magnitude
module bin8_to_bcd_seq #(
    parameter int SIGNED = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] value,
    output logic       busy,
    output logic       done,
    output logic       neg,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
    // so that the following doubling carries correctly into the next digit.
    function automatic logic [11:0] bcd_adjust(input logic [11:0] acc);
        logic [11:0] res;
        res = acc;
        for (int i = 0; i < 3; i++) begin
            if (acc[i*4 +: 4] >= 4'd5) begin
                res[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
            end else begin
                res[i*4 +: 4] = acc[i*4 +: 4];
            end
        end
        return res;
    endfunction

    state_t      state_r, state_s;
    logic [2:0]  cnt_r, cnt_s;
    logic [7:0]  shreg_r, shreg_s;
    logic [11:0] acc_r, acc_s;
    logic        sign_r, sign_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        neg_r, neg_s;
    logic [3:0]  hundreds_r, hundreds_s;
    logic [3:0]  tens_r, tens_s;
    logic [3:0]  ones_r, ones_s;

    logic [7:0]  mag_s;
    logic        in_sign_s;
    logic [19:0] step_s;

    // Input magnitude/sign and one double-dabble step of the current state.
    always_comb begin
        if ((SIGNED != 0) && value[7]) begin
            // 0x80 negates to 0x80, which read unsigned is the required 128.
            mag_s     = 8'd0 - value;
            in_sign_s = 1'b1;
        end else begin
            mag_s     = value;
            in_sign_s = 1'b0;
        end
        step_s = {bcd_adjust(acc_r), shreg_r} << 1;
    end

    // Next-state and next-output logic of the IDLE/CONV controller.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        shreg_s    = shreg_r;
        acc_s      = acc_r;
        sign_s     = sign_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        neg_s      = neg_r;
        hundreds_s = hundreds_r;
        tens_s     = tens_r;
        ones_s     = ones_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = CONV;
                    cnt_s   = 3'd0;
                    shreg_s = mag_s;
                    acc_s   = 12'd0;
                    sign_s  = in_sign_s;
                    busy_s  = 1'b1;
                end else begin
                    busy_s  = 1'b0;
                end
            end
            CONV: begin
                acc_s   = step_s[19:8];
                shreg_s = step_s[7:0];
                cnt_s   = cnt_r + 3'd1;
                if (cnt_r == 3'd7) begin
                    // Eighth shift: publish the digits straight from this step.
                    state_s    = IDLE;
                    cnt_s      = 3'd0;
                    busy_s     = 1'b0;
                    done_s     = 1'b1;
                    neg_s      = sign_r;
                    hundreds_s = step_s[19:16];
                    tens_s     = step_s[15:12];
                    ones_s     = step_s[11:8];
                end else begin
                    busy_s     = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 3'd0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= 3'd0;
            shreg_r    <= 8'd0;
            acc_r      <= 12'd0;
            sign_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            neg_r      <= 1'b0;
            hundreds_r <= 4'd0;
            tens_r     <= 4'd0;
            ones_r     <= 4'd0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            shreg_r    <= shreg_s;
            acc_r      <= acc_s;
            sign_r     <= sign_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            neg_r      <= neg_s;
            hundreds_r <= hundreds_s;
            tens_r     <= tens_s;
            ones_r     <= ones_s;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign neg      = neg_r;
    assign hundreds = hundreds_r;
    assign tens     = tens_r;
    assign ones     = ones_r;

endmodule
